// File: rtl/touch_tap_filter.sv
// touch_tap_filter
//
// Conditioning stage between the FT6336 touch poller and the home/game
// state machine. Raw panel coordinates are rotated into game coordinates
// (x from panel Y, y from inverted panel X, both clamped). Press and release
// are debounced over poll samples. The block emits one-cycle tap, release
// and long-press events and keeps a tracked paddle position.
//
// Optional feature: define TOUCH_SMOOTH_EN to run the tracked position
// through a first-order IIR (shift SMOOTH_SHIFT). Without the macro the
// position follows each sample directly.
//
// Ports:
//   clk          system clock (50 MHz)
//   reset        synchronous, active-high reset
//   touch_valid  one-cycle strobe per completed poll
//   touch_down   contact reported by the panel, qualified by touch_valid
//   touch_x/y    raw 12-bit panel coordinates, qualified by touch_valid
//   pressed      debounced contact level
//   tap          one-cycle pulse when a press is confirmed
//   tap_x/y      game coordinates of the confirming sample, held until next tap
//   release_evt  one-cycle pulse when a release is confirmed or forced
//                (named release_evt because "release" is a reserved word)
//   long_press   one-cycle pulse, at most once per press
//   pos_x/y      tracked game coordinates while pressed
//   pos_valid    equals pressed

module touch_tap_filter #(
    parameter int GAME_W            = 320,
    parameter int GAME_H            = 240,
    parameter int DEBOUNCE_N        = 2,
    parameter int RELEASE_N         = 3,
    parameter int LONG_PRESS_CYCLES = 25_000_000,
    parameter int STALE_CYCLES      = 2_500_000,
    parameter int SMOOTH_SHIFT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        touch_valid,
    input  logic        touch_down,
    input  logic [11:0] touch_x,
    input  logic [11:0] touch_y,
    output logic        pressed,
    output logic        tap,
    output logic [8:0]  tap_x,
    output logic [8:0]  tap_y,
    output logic        release_evt,
    output logic        long_press,
    output logic [8:0]  pos_x,
    output logic [8:0]  pos_y,
    output logic        pos_valid
);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_N < 1 || DEBOUNCE_N > 15 || RELEASE_N < 1 || RELEASE_N > 15
        || SMOOTH_SHIFT < 0 || SMOOTH_SHIFT > 8
        || LONG_PRESS_CYCLES < 1 || STALE_CYCLES < 1) begin : g_bad_cfg
        $error("touch_tap_filter: parameter out of range");
    end

    localparam logic [11:0] X_MAX12 = 12'(GAME_W - 1);
    localparam logic [11:0] Y_MAX12 = 12'(GAME_H - 1);
    localparam logic [8:0]  X_MAX9  = 9'(GAME_W - 1);
    localparam logic [8:0]  Y_MAX9  = 9'(GAME_H - 1);
    localparam logic [3:0]  DEB_N   = 4'(DEBOUNCE_N);
    localparam logic [3:0]  REL_N   = 4'(RELEASE_N);

    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

    typedef enum logic [1:0] {
        S_UP,
        S_PRESS_PEND,
        S_DOWN,
        S_REL_PEND
    } state_t;

    state_t state, state_d;

    logic [3:0]         cnt, cnt_d;
    logic [3:0]         rcnt, rcnt_d;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STALE_W-1:0] stale_cnt;

    logic       s_v;
    logic       s_down;
    logic [8:0] s_gx;
    logic [8:0] s_gy;

    logic [8:0] gx_c;
    logic [8:0] gy_clamp;
    logic [8:0] gy_c;

    logic       confirm;
    logic       track;
    logic       tap_d;
    logic       rel_d;
    logic       stale_hit;
    logic       held;
    logic [8:0] pos_x_next;
    logic [8:0] pos_y_next;

    // Rotation: game x comes from panel Y, game y from inverted panel X.
    // Comparisons use the full 12 bits so large raw values clamp correctly.
    always_comb begin
        gx_c     = (touch_y > X_MAX12) ? X_MAX9 : touch_y[8:0];
        gy_clamp = (touch_x > Y_MAX12) ? Y_MAX9 : touch_x[8:0];
        gy_c     = Y_MAX9 - gy_clamp;
    end

    // Stage 1 register: the FSM only ever sees this registered sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_v    <= 1'b0;
            s_down <= 1'b0;
            s_gx   <= '0;
            s_gy   <= '0;
        end else begin
            s_v <= touch_valid;
            if (touch_valid) begin
                s_down <= touch_down;
                s_gx   <= gx_c;
                s_gy   <= gy_c;
            end
        end
    end

    // Poll-silence timer. It saturates, so a timeout stays asserted until the
    // next strobe; that is harmless because the FSM leaves the pressed states.
    always_ff @(posedge clk) begin
        if (reset) begin
            stale_cnt <= '0;
        end else if (touch_valid) begin
            stale_cnt <= '0;
        end else if (stale_cnt != STALE_MAX) begin
            stale_cnt <= stale_cnt + 1'b1;
        end
    end

    // A fresh sample always beats a timeout in the same cycle.
    assign stale_hit = (stale_cnt == STALE_MAX) && !s_v;
    assign held      = (state == S_DOWN) || (state == S_REL_PEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_UP;
            cnt   <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rcnt  <= rcnt_d;
        end
    end

    // Debounce FSM. Only s_v advances the counters; the stale timeout is the
    // only way to leave a state without a sample.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rcnt_d  = rcnt;
        confirm = 1'b0;
        track   = 1'b0;
        rel_d   = 1'b0;

        case (state)
            S_UP: begin
                if (s_v && s_down) begin
                    if (DEB_N == 4'd1) begin
                        confirm = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DOWN;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = S_PRESS_PEND;
                    end
                end
            end

            S_PRESS_PEND: begin
                if (s_v) begin
                    if (s_down) begin
                        if (cnt + 4'd1 == DEB_N) begin
                            confirm = 1'b1;
                            cnt_d   = '0;
                            state_d = S_DOWN;
                        end else begin
                            cnt_d = cnt + 4'd1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_UP;
                    end
                end else if (stale_hit) begin
                    cnt_d   = '0;
                    state_d = S_UP;
                end
            end

            S_DOWN: begin
                if (s_v) begin
                    if (s_down) begin
                        track = 1'b1;
                    end else if (REL_N == 4'd1) begin
                        rel_d   = 1'b1;
                        rcnt_d  = '0;
                        state_d = S_UP;
                    end else begin
                        rcnt_d  = 4'd1;
                        state_d = S_REL_PEND;
                    end
                end else if (stale_hit) begin
                    rel_d   = 1'b1;
                    rcnt_d  = '0;
                    state_d = S_UP;
                end
            end

            S_REL_PEND: begin
                if (s_v) begin
                    if (!s_down) begin
                        if (rcnt + 4'd1 == REL_N) begin
                            rel_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = S_UP;
                        end else begin
                            rcnt_d = rcnt + 4'd1;
                        end
                    end else begin
                        track   = 1'b1;
                        rcnt_d  = '0;
                        state_d = S_DOWN;
                    end
                end else if (stale_hit) begin
                    rel_d   = 1'b1;
                    rcnt_d  = '0;
                    state_d = S_UP;
                end
            end

            default: begin
                state_d = S_UP;
                cnt_d   = '0;
                rcnt_d  = '0;
            end
        endcase
    end

    assign tap_d = confirm;

`ifdef TOUCH_SMOOTH_EN
    // IIR step pos += (sample - pos) >>> SMOOTH_SHIFT in signed arithmetic,
    // then clamped back into the playfield.
    logic signed [9:0]  diff_x, diff_y;
    logic signed [9:0]  step_x, step_y;
    logic signed [10:0] sum_x, sum_y;

    always_comb begin
        diff_x = $signed({1'b0, s_gx}) - $signed({1'b0, pos_x});
        diff_y = $signed({1'b0, s_gy}) - $signed({1'b0, pos_y});
        step_x = diff_x >>> SMOOTH_SHIFT;
        step_y = diff_y >>> SMOOTH_SHIFT;
        sum_x  = $signed({2'b00, pos_x}) + 11'(step_x);
        sum_y  = $signed({2'b00, pos_y}) + 11'(step_y);

        if (sum_x < 0)
            pos_x_next = '0;
        else if (sum_x > $signed({2'b00, X_MAX9}))
            pos_x_next = X_MAX9;
        else
            pos_x_next = sum_x[8:0];

        if (sum_y < 0)
            pos_y_next = '0;
        else if (sum_y > $signed({2'b00, Y_MAX9}))
            pos_y_next = Y_MAX9;
        else
            pos_y_next = sum_y[8:0];
    end
`else
    always_comb begin
        pos_x_next = s_gx;
        pos_y_next = s_gy;
    end
`endif

    // Registered event outputs and coordinates. The confirming sample loads
    // pos directly so a new press never smooths from the previous position.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap         <= 1'b0;
            release_evt <= 1'b0;
            pressed     <= 1'b0;
            tap_x       <= '0;
            tap_y       <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
        end else begin
            tap         <= tap_d;
            release_evt <= rel_d;
            pressed     <= (state_d == S_DOWN) || (state_d == S_REL_PEND);
            if (confirm) begin
                tap_x <= s_gx;
                tap_y <= s_gy;
                pos_x <= s_gx;
                pos_y <= s_gy;
            end else if (track) begin
                pos_x <= pos_x_next;
                pos_y <= pos_y_next;
            end
        end
    end

    // Hold timer: hits HOLD_FIRE exactly once per press because it only
    // counts upward and is cleared on each confirm.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= held && (hold_cnt == HOLD_FIRE);
            if (confirm)
                hold_cnt <= '0;
            else if (held && hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign pos_valid = pressed;

endmodule

// File: tb/tb_touch_tap_filter.sv
// Testbench for touch_tap_filter. Uses shortened long-press and stale
// intervals so the multi-cycle corner cases fit in a short run.
module tb_touch_tap_filter;

    localparam int LP = 400;
    localparam int ST = 150;

    logic        clk = 1'b0;
    logic        reset;
    logic        touch_valid;
    logic        touch_down;
    logic [11:0] touch_x;
    logic [11:0] touch_y;
    logic        pressed;
    logic        tap;
    logic [8:0]  tap_x;
    logic [8:0]  tap_y;
    logic        release_evt;
    logic        long_press;
    logic [8:0]  pos_x;
    logic [8:0]  pos_y;
    logic        pos_valid;

    always #5 clk = ~clk;

    touch_tap_filter #(
        .GAME_W(320),
        .GAME_H(240),
        .DEBOUNCE_N(2),
        .RELEASE_N(3),
        .LONG_PRESS_CYCLES(LP),
        .STALE_CYCLES(ST),
        .SMOOTH_SHIFT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .touch_valid(touch_valid),
        .touch_down(touch_down),
        .touch_x(touch_x),
        .touch_y(touch_y),
        .pressed(pressed),
        .tap(tap),
        .tap_x(tap_x),
        .tap_y(tap_y),
        .release_evt(release_evt),
        .long_press(long_press),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .pos_valid(pos_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event monitor sampled on the falling edge, away from the active edge.
    int cyc       = 0;
    int tap_cyc   = 0;
    int rel_cyc   = 0;
    int lp_cyc    = 0;
    int rel_count = 0;
    int lp_count  = 0;
    int both_cnt  = 0;

    always @(negedge clk) begin
        cyc++;
        if (tap) tap_cyc = cyc;
        if (release_evt) begin
            rel_count++;
            rel_cyc = cyc;
        end
        if (long_press) begin
            lp_count++;
            lp_cyc = cyc;
        end
        if (tap && release_evt) both_cnt++;
    end

    typedef struct {
        logic        down;
        logic [11:0] x;
        logic [11:0] y;
        logic        e_tap;
        logic        e_rel;
        logic        e_pressed;
        logic [8:0]  e_tx;
        logic [8:0]  e_ty;
        logic [8:0]  e_px;
        logic [8:0]  e_py;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One poll strobe; returns 1 time unit after the edge that samples it.
    task automatic applyStimulus(input logic down, input logic [11:0] x, input logic [11:0] y);
        @(posedge clk);
        #1;
        touch_valid = 1'b1;
        touch_down  = down;
        touch_x     = x;
        touch_y     = y;
        @(posedge clk);
        #1;
        touch_valid = 1'b0;
        touch_down  = 1'b0;
    endtask

    int rel0;
    int lp0;
    logic [8:0] px5;
    logic [8:0] py5;

    initial begin
        reset       = 1'b1;
        touch_valid = 1'b0;
        touch_down  = 1'b0;
        touch_x     = '0;
        touch_y     = '0;

`ifdef TOUCH_SMOOTH_EN
        // 300 + ((100-300) >>> 2) = 250 ; 219 + ((189-219) >>> 2) = 211
        px5 = 9'd250;
        py5 = 9'd211;
`else
        px5 = 9'd100;
        py5 = 9'd189;
`endif

        //            down  x         y         tap  rel  prs  tx      ty      px      py
        vecs[0]  = '{1'b1, 12'd20,   12'd300,  1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   9'd0,   9'd0};
        vecs[1]  = '{1'b1, 12'd20,   12'd300,  1'b1, 1'b0, 1'b1, 9'd300, 9'd219, 9'd300, 9'd219};
        vecs[2]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b1, 9'd300, 9'd219, 9'd300, 9'd219};
        vecs[3]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b1, 9'd300, 9'd219, 9'd300, 9'd219};
        vecs[4]  = '{1'b1, 12'd50,   12'd100,  1'b0, 1'b0, 1'b1, 9'd300, 9'd219, px5,    py5};
        vecs[5]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b1, 9'd300, 9'd219, px5,    py5};
        vecs[6]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b1, 9'd300, 9'd219, px5,    py5};
        vecs[7]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b1, 1'b0, 9'd300, 9'd219, px5,    py5};
        vecs[8]  = '{1'b1, 12'd4000, 12'd4000, 1'b0, 1'b0, 1'b0, 9'd300, 9'd219, px5,    py5};
        vecs[9]  = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b0, 9'd300, 9'd219, px5,    py5};
        vecs[10] = '{1'b1, 12'd4000, 12'd4000, 1'b0, 1'b0, 1'b0, 9'd300, 9'd219, px5,    py5};
        vecs[11] = '{1'b1, 12'd4000, 12'd4000, 1'b1, 1'b0, 1'b1, 9'd319, 9'd0,   9'd319, 9'd0};
        vecs[12] = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b1, 9'd319, 9'd0,   9'd319, 9'd0};
        vecs[13] = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b1, 9'd319, 9'd0,   9'd319, 9'd0};
        vecs[14] = '{1'b0, 12'd0,    12'd0,    1'b0, 1'b1, 1'b0, 9'd319, 9'd0,   9'd319, 9'd0};

        // Reset state
        tick(3);
        checkOutput("rst_pressed", pressed, 0);
        checkOutput("rst_tap", tap, 0);
        checkOutput("rst_release", release_evt, 0);
        checkOutput("rst_long", long_press, 0);
        checkOutput("rst_tap_x", tap_x, 0);
        checkOutput("rst_pos_x", pos_x, 0);
        checkOutput("rst_pos_valid", pos_valid, 0);
        reset = 1'b0;
        tick(2);

        // Table-driven strobe sequence: events land two edges after the strobe.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].down, vecs[i].x, vecs[i].y);
            checkOutput($sformatf("v%0d_early_tap", i), tap, 0);
            checkOutput($sformatf("v%0d_early_rel", i), release_evt, 0);
            tick(1);
            checkOutput($sformatf("v%0d_tap", i), tap, vecs[i].e_tap);
            checkOutput($sformatf("v%0d_release", i), release_evt, vecs[i].e_rel);
            checkOutput($sformatf("v%0d_pressed", i), pressed, vecs[i].e_pressed);
            checkOutput($sformatf("v%0d_pos_valid", i), pos_valid, vecs[i].e_pressed);
            checkOutput($sformatf("v%0d_tap_x", i), tap_x, vecs[i].e_tx);
            checkOutput($sformatf("v%0d_tap_y", i), tap_y, vecs[i].e_ty);
            checkOutput($sformatf("v%0d_pos_x", i), pos_x, vecs[i].e_px);
            checkOutput($sformatf("v%0d_pos_y", i), pos_y, vecs[i].e_py);
            tick(1);
            checkOutput($sformatf("v%0d_tap_1cyc", i), tap, 0);
            checkOutput($sformatf("v%0d_rel_1cyc", i), release_evt, 0);
        end

        // Stale timeout while pressed: forced release ST cycles after the tap.
        rel0 = rel_count;
        lp0  = lp_count;
        applyStimulus(1'b1, 12'd20, 12'd300);
        applyStimulus(1'b1, 12'd20, 12'd300);
        tick(ST + 40);
        checkOutput("stale_rel_count", rel_count - rel0, 1);
        checkOutput("stale_rel_delay", rel_cyc - tap_cyc, ST);
        checkOutput("stale_pressed", pressed, 0);
        checkOutput("stale_no_long", lp_count - lp0, 0);

        // Long press with regular strobes: exactly one pulse LP cycles after tap.
        rel0 = rel_count;
        lp0  = lp_count;
        applyStimulus(1'b1, 12'd20, 12'd300);
        applyStimulus(1'b1, 12'd20, 12'd300);
        for (int k = 0; k < 6; k++) begin
            tick(99);
            applyStimulus(1'b1, 12'd20, 12'd300);
        end
        checkOutput("long_count", lp_count - lp0, 1);
        checkOutput("long_delay", lp_cyc - tap_cyc, LP);
        checkOutput("long_no_rel", rel_count - rel0, 0);
        checkOutput("long_pressed", pressed, 1);
        applyStimulus(1'b0, 12'd0, 12'd0);
        applyStimulus(1'b0, 12'd0, 12'd0);
        applyStimulus(1'b0, 12'd0, 12'd0);
        tick(2);
        checkOutput("long_end_rel", rel_count - rel0, 1);
        checkOutput("long_end_count", lp_count - lp0, 1);
        checkOutput("long_end_pressed", pressed, 0);

        // Reset mid-press: outputs clear, no release pulse, no later timeout.
        applyStimulus(1'b1, 12'd20, 12'd300);
        applyStimulus(1'b1, 12'd20, 12'd300);
        tick(3);
        checkOutput("pre_rst_pressed", pressed, 1);
        rel0 = rel_count;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("mid_rst_pressed", pressed, 0);
        checkOutput("mid_rst_tap_x", tap_x, 0);
        checkOutput("mid_rst_pos_x", pos_x, 0);
        tick(ST + 40);
        checkOutput("mid_rst_no_rel", rel_count - rel0, 0);
        checkOutput("mid_rst_still_up", pressed, 0);

        checkOutput("tap_rel_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
